// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - ISA opcodes, format groups, controller states and word packing.
package instr_encoder_pkg;

  localparam logic [4:0] OP_ADR  = 5'b00001;
  localparam logic [4:0] OP_SBR  = 5'b00101;
  localparam logic [4:0] OP_MLR  = 5'b01001;
  localparam logic [4:0] OP_BBO  = 5'b01100;
  localparam logic [4:0] OP_JMR  = 5'b11100;
  localparam logic [4:0] OP_ADM0 = 5'b00010;
  localparam logic [4:0] OP_ADM1 = 5'b00011;
  localparam logic [4:0] OP_SBM0 = 5'b00110;
  localparam logic [4:0] OP_SBM1 = 5'b00111;
  localparam logic [4:0] OP_ADI  = 5'b00100;
  localparam logic [4:0] OP_SBI  = 5'b01000;
  localparam logic [4:0] OP_XSL  = 5'b01010;
  localparam logic [4:0] OP_XSR  = 5'b01011;
  localparam logic [4:0] OP_LDR  = 5'b01110;
  localparam logic [4:0] OP_STI  = 5'b01111;
  localparam logic [4:0] OP_STK  = 5'b01101;

  typedef enum logic [2:0] {FMT_R, FMT_M, FMT_I, FMT_S, FMT_L, FMT_K, FMT_ILL} fmt_e;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_DONE} state_e;

  typedef struct packed {
    logic [4:0]  op;
    logic [1:0]  rn;
    logic [1:0]  rm;
    logic [1:0]  rx;
    logic [1:0]  cmode;
    logic [1:0]  smode;
    logic [3:0]  amt;
    logic        shf;
    logic [10:0] imm;
  } req_t;

  function automatic fmt_e decode_fmt(input logic [4:0] op);
    fmt_e f;
    case (op)
      OP_ADR, OP_SBR, OP_MLR, OP_BBO, OP_JMR:   f = FMT_R;
      OP_ADM0, OP_ADM1, OP_SBM0, OP_SBM1:       f = FMT_M;
      OP_ADI, OP_SBI:                           f = FMT_I;
      OP_XSL, OP_XSR:                           f = FMT_S;
      OP_LDR, OP_STI:                           f = FMT_L;
      OP_STK:                                   f = FMT_K;
      default:                                  f = FMT_ILL;
    endcase
    return f;
  endfunction

  // M-format steals opcode bit 0 for RN[0]; every other group keeps the full opcode on top.
  function automatic logic [15:0] pack_word(input req_t r);
    logic [15:0] w;
    w = {r.op, 11'd0};
    case (decode_fmt(r.op))
      FMT_R:   w[10:0] = {1'b0, r.cmode, r.smode, r.rx, r.rn, r.rm};
      FMT_M:   w = {r.op[4:1], r.rn[0], r.imm};
      FMT_I:   w[10:0] = {r.rn, r.imm[8:0]};
      FMT_S:   w[10:0] = {1'b0, r.cmode, r.amt, 2'b00, r.rm};
      FMT_L:   w[10:0] = {2'b00, r.shf, r.rn, r.rm, r.amt};
      FMT_K:   w[10:0] = r.imm;
      default: w = 16'd0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_encoder_word_fifo.sv
// rtl/instr_encoder_word_fifo.sv - DEPTH-entry word FIFO holding encoded words awaiting memory writes.
module word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PW:0]                 wr_ptr_q, wr_ptr_d;
  logic [PW:0]                 rd_ptr_q, rd_ptr_d;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign rdata = mem_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[PW-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + (PW+1)'(1);
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs instruction requests into 16-bit words and streams them to program memory.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          START,
  input  logic [AW-1:0] BASE,
  input  logic          FINISH,
  input  logic          REQ_VALID,
  output logic          REQ_READY,
  input  logic [4:0]    OP,
  input  logic [1:0]    RN,
  input  logic [1:0]    RM,
  input  logic [1:0]    RX,
  input  logic [1:0]    CMODE,
  input  logic [1:0]    SMODE,
  input  logic [3:0]    AMT,
  input  logic          SHF,
  input  logic [10:0]   IMM,
  output logic          MEM_WE,
  output logic [AW-1:0] MEM_ADDR,
  output logic [15:0]   MEM_WDATA,
  input  logic          MEM_READY,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR,
  output logic [AW:0]   COUNT
);

  localparam logic [AW:0] COUNT_MAX = {1'b1, {AW{1'b0}}};

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   count_q, count_d;
  logic          err_q, err_d;

  req_t        req;
  logic        legal;
  logic [15:0] word;
  logic        fifo_full, fifo_empty;
  logic        accept, push, pop;

  assign req   = '{op: OP, rn: RN, rm: RM, rx: RX, cmode: CMODE, smode: SMODE,
                   amt: AMT, shf: SHF, imm: IMM};
  assign legal = (decode_fmt(OP) != FMT_ILL);
  assign word  = pack_word(req);

  // Outputs are gated by RESET so a reset cycle never performs a write or handshake.
  assign REQ_READY = !RESET && (state_q == ST_LOAD) && !fifo_full;
  assign MEM_WE    = !RESET && ((state_q == ST_LOAD) || (state_q == ST_DRAIN)) && !fifo_empty;
  assign accept    = REQ_VALID && REQ_READY;
  assign push      = accept && legal;
  assign pop       = MEM_WE && MEM_READY;

  assign MEM_ADDR = addr_q;
  assign BUSY     = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign DONE     = (state_q == ST_DONE);
  assign ERR      = err_q;
  assign COUNT    = count_q;

  word_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (push),
    .wdata (word),
    .pop   (pop),
    .rdata (MEM_WDATA),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          state_d = ST_LOAD;
          addr_d  = BASE;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (FINISH) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept && !legal) err_d = 1'b1;

    if (pop) begin
      addr_d = addr_q + AW'(1);
      if (count_q != COUNT_MAX) count_d = count_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized and directed self-checking bench for instr_encoder.
module tb_instr_encoder;

  localparam int DEPTH = 4;
  localparam int AW    = 8;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          START = 1'b0;
  logic [AW-1:0] BASE = '0;
  logic          FINISH = 1'b0;
  logic          REQ_VALID = 1'b0;
  logic          REQ_READY;
  logic [4:0]    OP = '0;
  logic [1:0]    RN = '0, RM = '0, RX = '0, CMODE = '0, SMODE = '0;
  logic [3:0]    AMT = '0;
  logic          SHF = 1'b0;
  logic [10:0]   IMM = '0;
  logic          MEM_WE;
  logic [AW-1:0] MEM_ADDR;
  logic [15:0]   MEM_WDATA;
  logic          MEM_READY = 1'b0;
  logic          BUSY, DONE, ERR;
  logic [AW:0]   COUNT;

  instr_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .BASE(BASE), .FINISH(FINISH),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .OP(OP), .RN(RN), .RM(RM),
    .RX(RX), .CMODE(CMODE), .SMODE(SMODE), .AMT(AMT), .SHF(SHF), .IMM(IMM),
    .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_READY(MEM_READY), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding written as field arithmetic per format group.
  function automatic bit model_encode(input int op, rn, rm, rx, cm, sm, amt, shf, imm,
                                      output int w);
    bit ok = 1;
    case (op)
      1, 5, 9, 12, 28: w = op*2048 + cm*256 + sm*64 + rx*16 + rn*4 + rm;
      2, 3, 6, 7:      w = (op/2)*4096 + (rn%2)*2048 + imm;
      4, 8:            w = op*2048 + rn*512 + (imm%512);
      10, 11:          w = op*2048 + cm*256 + amt*16 + rm;
      14, 15:          w = op*2048 + shf*256 + rn*64 + rm*16 + amt;
      13:              w = op*2048 + imm;
      default: begin ok = 0; w = 0; end
    endcase
    return ok;
  endfunction

  // Behavioural model: mode 0 idle, 1 load, 2 drain, 3 done.
  int mode = 0;
  int m_addr = 0;
  int m_count = 0;
  bit m_err = 0;
  bit model_valid = 0;
  int q[$];

  always @(posedge CLK) begin
    if (RESET) begin
      mode = 0; m_addr = 0; m_count = 0; m_err = 0; q.delete();
      model_valid = 1;
    end else if (model_valid) begin
      int  old_size;
      bit  rdy, we, acc, lg;
      int  w;
      old_size = q.size();
      rdy = (mode == 1) && (old_size < DEPTH);
      we  = (mode == 1 || mode == 2) && (old_size > 0);
      acc = REQ_VALID && rdy;
      if (we && MEM_READY) begin
        void'(q.pop_front());
        m_addr = (m_addr + 1) % 256;
        if (m_count < 256) m_count++;
      end
      if (acc) begin
        lg = model_encode(OP, RN, RM, RX, CMODE, SMODE, AMT, SHF, IMM, w);
        if (lg) q.push_back(w);
        else m_err = 1;
      end
      if ((mode == 0 || mode == 3) && START) begin
        mode = 1; m_addr = BASE; m_count = 0; m_err = 0;
      end else if (mode == 1 && FINISH) begin
        mode = 2;
      end else if (mode == 2 && old_size == 0) begin
        mode = 3;
      end
    end
  end

  always @(negedge CLK) begin
    if (RESET) begin
      chk("we_during_reset", MEM_WE, 0);
    end else if (model_valid) begin
      bit exp_we;
      exp_we = (mode == 1 || mode == 2) && q.size() > 0;
      chk("mem_we", MEM_WE, exp_we);
      if (exp_we && MEM_WE) begin
        chk("mem_wdata", MEM_WDATA, q[0]);
        chk("mem_addr", MEM_ADDR, m_addr);
      end
      chk("req_ready", REQ_READY, (mode == 1) && (q.size() < DEPTH));
      chk("busy", BUSY, (mode == 1 || mode == 2));
      chk("done", DONE, mode == 3);
      chk("err", ERR, m_err);
      chk("count", COUNT, m_count);
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    RESET = 1; START = 0; FINISH = 0; REQ_VALID = 0;
    tick;
    RESET = 0;
  endtask

  task automatic do_start(input logic [AW-1:0] b);
    START = 1; BASE = b;
    tick;
    START = 0;
  endtask

  task automatic do_finish;
    FINISH = 1;
    tick;
    FINISH = 0;
  endtask

  task automatic send(input logic [4:0] op, input logic [1:0] rn, rm, rx, cm, sm,
                      input logic [3:0] amt, input logic shf, input logic [10:0] imm);
    bit ok = 0;
    OP = op; RN = rn; RM = rm; RX = rx; CMODE = cm; SMODE = sm; AMT = amt; SHF = shf; IMM = imm;
    REQ_VALID = 1;
    for (int i = 0; i < 100; i++) begin
      if (REQ_READY) begin
        tick;
        ok = 1;
        break;
      end
      tick;
    end
    REQ_VALID = 0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_done;
    for (int i = 0; i < 50; i++) begin
      if (DONE) break;
      tick;
    end
    chk("wait_done", DONE, 1);
  endtask

  int legal_ops[16] = '{1, 5, 9, 12, 28, 2, 3, 6, 7, 4, 8, 10, 11, 14, 15, 13};

  initial begin
    int w;
    tick; tick;
    RESET = 0;

    // Model pinning against hand-computed words.
    void'(model_encode(1, 2, 1, 3, 1, 2, 0, 0, 0, w));   chk("model_adr", w, 32'h09B9);
    void'(model_encode(4, 3, 0, 0, 0, 0, 0, 0, 'h1FF, w)); chk("model_adi", w, 32'h27FF);
    void'(model_encode(6, 1, 0, 0, 0, 0, 0, 0, 'h123, w)); chk("model_sbm", w, 32'h3923);
    chk("model_illegal", model_encode(16, 0, 0, 0, 0, 0, 0, 0, 0, w), 0);

    chk("reset_we", MEM_WE, 0);
    chk("reset_ready", REQ_READY, 0);
    chk("reset_count", COUNT, 0);
    chk("reset_idle", {BUSY, DONE, ERR}, 0);

    // Single adr word.
    MEM_READY = 0;
    do_start(8'h10);
    send(5'b00001, 2, 1, 3, 1, 2, 0, 0, 0);
    chk("adr_we", MEM_WE, 1);
    chk("adr_addr", MEM_ADDR, 8'h10);
    chk("adr_data", MEM_WDATA, 16'h09B9);
    tick;
    chk("adr_hold", MEM_WDATA, 16'h09B9);
    MEM_READY = 1;
    tick;
    chk("adr_count", COUNT, 1);

    // adi then sbm back to back.
    do_reset;
    MEM_READY = 1;
    do_start(8'h20);
    send(5'b00100, 3, 0, 0, 0, 0, 0, 0, 11'h1FF);
    chk("adi_data", MEM_WDATA, 16'h27FF);
    chk("adi_addr", MEM_ADDR, 8'h20);
    send(5'b00110, 1, 0, 0, 0, 0, 0, 0, 11'h123);
    chk("sbm_data", MEM_WDATA, 16'h3923);
    chk("sbm_addr", MEM_ADDR, 8'h21);
    tick;
    chk("two_count", COUNT, 2);

    // Backpressure: FIFO fills at DEPTH.
    do_reset;
    MEM_READY = 0;
    do_start(8'h40);
    for (int i = 0; i < 4; i++) send(5'b01101, 0, 0, 0, 0, 0, 0, 0, 11'(i + 1));
    chk("full_ready", REQ_READY, 0);
    MEM_READY = 1;
    send(5'b01101, 0, 0, 0, 0, 0, 0, 0, 11'd5);
    do_finish;
    wait_done;
    chk("full_count", COUNT, 5);

    // Illegal opcode.
    do_reset;
    MEM_READY = 1;
    do_start(8'h00);
    send(5'b00100, 0, 0, 0, 0, 0, 0, 0, 11'd7);
    send(5'b10000, 0, 0, 0, 0, 0, 0, 0, 11'd0);
    chk("ill_err", ERR, 1);
    chk("ill_we", MEM_WE, 0);
    chk("ill_count", COUNT, 1);
    do_finish;
    wait_done;
    do_start(8'h00);
    chk("ill_cleared", ERR, 0);

    // Address wrap and drain ordering.
    do_reset;
    MEM_READY = 0;
    do_start(8'hFF);
    send(5'b01101, 0, 0, 0, 0, 0, 0, 0, 11'h0AA);
    send(5'b01101, 0, 0, 0, 0, 0, 0, 0, 11'h055);
    do_finish;
    chk("wrap_addr0", MEM_ADDR, 8'hFF);
    chk("wrap_notdone", DONE, 0);
    MEM_READY = 1;
    tick;
    chk("wrap_addr1", MEM_ADDR, 8'h00);
    chk("wrap_we1", MEM_WE, 1);
    tick;
    chk("wrap_done_late", DONE, 0);
    tick;
    chk("wrap_done", DONE, 1);

    // Reset while draining.
    do_reset;
    MEM_READY = 0;
    do_start(8'h30);
    for (int i = 0; i < 3; i++) send(5'b01110, 1, 2, 0, 0, 0, 4'(i), 1, 0);
    do_finish;
    chk("drain_busy", BUSY, 1);
    RESET = 1;
    #1;
    chk("rst_we_now", MEM_WE, 0);
    tick;
    RESET = 0;
    chk("rst_we", MEM_WE, 0);
    chk("rst_count", COUNT, 0);
    chk("rst_busy", BUSY, 0);

    // Randomized traffic, compared every cycle by the model.
    for (int c = 0; c < 4000; c++) begin
      int r;
      RESET     = ($urandom_range(0, 399) == 0);
      START     = (DONE || !BUSY) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      FINISH    = ($urandom_range(0, 24) == 0);
      BASE      = AW'($urandom);
      REQ_VALID = $urandom_range(0, 2) != 0;
      MEM_READY = $urandom_range(0, 2) != 0;
      r = $urandom_range(0, 19);
      OP    = (r == 0) ? 5'($urandom) : 5'(legal_ops[$urandom_range(0, 15)]);
      RN    = 2'($urandom); RM = 2'($urandom); RX = 2'($urandom);
      CMODE = 2'($urandom); SMODE = 2'($urandom);
      AMT   = 4'($urandom); SHF = 1'($urandom); IMM = 11'($urandom);
      tick;
    end
    RESET = 0; START = 0; FINISH = 0; REQ_VALID = 0;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
